// File: rtl/burst_decode.sv
// burst_decode
//   Recovers (base, length) bursts from a stream of W-bit addresses. A burst
//   is a maximal run of addresses stepping by one modulo 2^W. A run closes on
//   a non-contiguous beat, a forced restart (in_start), length saturation at
//   2^LW-1 beats, or flush. Each closed run is emitted as one descriptor
//   through a single-entry valid/ready output register.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : address beat handshake
//   in_addr         : address beat
//   in_start        : beat begins a new burst regardless of contiguity
//   flush           : close any open burst without a new beat
//   out_valid/ready : descriptor handshake
//   out_base        : first address of the burst
//   out_len         : number of beats in the burst (>= 1)
//   busy            : a burst is currently open
module burst_decode #(
  parameter int W  = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_addr,
  input  logic          in_start,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_base,
  output logic [LW-1:0] out_len,
  output logic          busy
);

  localparam logic [LW-1:0] LEN_MAX = {LW{1'b1}};
  localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] addr_inc(input logic [W-1:0] a);
    return a + {{(W-1){1'b0}}, 1'b1};
  endfunction

  logic          active;
  logic [W-1:0]  cur_base;
  logic [W-1:0]  cur_next;
  logic [LW-1:0] cur_len;

  logic slot_free;
  logic accept;
  logic cont;
  logic do_flush;
  logic emit;

  // The output slot is free when empty or being drained this cycle; flush
  // has priority over beats, so no beat is taken while it is asserted.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !flush;
  assign accept    = in_valid && in_ready;

  assign cont     = active && !in_start && (in_addr == cur_next) && (cur_len != LEN_MAX);
  assign do_flush = flush && active && slot_free;
  assign emit     = (accept && active && !cont) || do_flush;

  assign busy = active;

  // Run tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cur_base <= '0;
      cur_next <= '0;
      cur_len  <= '0;
    end else if (accept) begin
      if (cont) begin
        cur_len  <= cur_len + LEN_ONE;
        cur_next <= addr_inc(cur_next);
      end else begin
        // Idle start or break: the beat opens a fresh run.
        active   <= 1'b1;
        cur_base <= in_addr;
        cur_next <= addr_inc(in_addr);
        cur_len  <= LEN_ONE;
      end
    end else if (do_flush) begin
      active <= 1'b0;
    end
  end

  // Descriptor output register; a new emit replaces a descriptor that is
  // being drained in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_base  <= '0;
      out_len   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_base  <= cur_base;
      out_len   <= cur_len;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_burst_decode.sv
module tb_burst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_start, flush, out_ready;
  logic [15:0] in_addr;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_base;
  logic [15:0] out_len;

  // Second instance with a 2-bit length counter for saturation.
  logic        s_in_valid, s_in_start, s_flush, s_out_ready;
  logic [15:0] s_in_addr;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_out_base;
  logic [1:0]  s_out_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  burst_decode #(.W(16), .LW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_start(in_start), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_base(out_base),
    .out_len(out_len), .busy(busy)
  );

  burst_decode #(.W(16), .LW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_addr(s_in_addr), .in_start(s_in_start), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_base(s_out_base),
    .out_len(s_out_len), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle.
  task automatic beat(input logic [15:0] a, input logic st);
    in_valid = 1'b1; in_addr = a; in_start = st;
    tick();
    in_valid = 1'b0; in_start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_base !== 16'h0) begin failures++; $display("FAIL reset_out_base got=%h exp=0000", out_base); end
    checks++; if (out_len !== 16'h0) begin failures++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    flush = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_flush got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_flush_no_emit got=%0b exp=0", out_valid); end
  endtask

  task automatic test_contiguous();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(16'h0100 + 16'(i), 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL contig_no_emit[%0d] got=%0b exp=0", i, out_valid); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL contig_busy got=%0b exp=1", busy); end
    do_flush();
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h0100, 16'd4})
      begin failures++; $display("FAIL contig_desc got=%0b/%h/%0d exp=1/0100/4", out_valid, out_base, out_len); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL contig_busy_after got=%0b exp=0", busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL contig_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_break();
    beat(16'h0010, 1'b0);
    beat(16'h0011, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL break_early got=%0b exp=0", out_valid); end
    beat(16'h0020, 1'b0);
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h0010, 16'd2})
      begin failures++; $display("FAIL break_desc1 got=%0b/%h/%0d exp=1/0010/2", out_valid, out_base, out_len); end
    beat(16'h0021, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL break_cont got=%0b exp=0", out_valid); end
    do_flush();
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h0020, 16'd2})
      begin failures++; $display("FAIL break_desc2 got=%0b/%h/%0d exp=1/0020/2", out_valid, out_base, out_len); end
    tick();
  endtask

  task automatic test_forced_restart();
    beat(16'h8000, 1'b0);
    beat(16'h8001, 1'b1);
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h8000, 16'd1})
      begin failures++; $display("FAIL restart_desc1 got=%0b/%h/%0d exp=1/8000/1", out_valid, out_base, out_len); end
    do_flush();
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h8001, 16'd1})
      begin failures++; $display("FAIL restart_desc2 got=%0b/%h/%0d exp=1/8001/1", out_valid, out_base, out_len); end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] addrs [4];
    addrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      beat(addrs[i], 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_no_emit[%0d] got=%0b exp=0", i, out_valid); end
    end
    do_flush();
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'hFFFE, 16'd4})
      begin failures++; $display("FAIL wrap_desc got=%0b/%h/%0d exp=1/fffe/4", out_valid, out_base, out_len); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4];
    addrs = '{16'h0001, 16'h0003, 16'h0005, 16'h0007};
    for (int i = 0; i < 4; i++) begin
      beat(addrs[i], 1'b0);
      if (i > 0) begin
        checks++; if ({out_valid, out_base, out_len} !== {1'b1, addrs[i-1], 16'd1})
          begin failures++; $display("FAIL b2b_desc[%0d] got=%0b/%h/%0d exp=1/%h/1", i, out_valid, out_base, out_len, addrs[i-1]); end
      end
    end
    do_flush();
    checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h0007, 16'd1})
      begin failures++; $display("FAIL b2b_last got=%0b/%h/%0d exp=1/0007/1", out_valid, out_base, out_len); end
    tick();
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0;
    beat(16'h0040, 1'b0);
    beat(16'h0050, 1'b0);
    flush = 1'b1;
    tick();
    checks++; if ({out_valid, out_base, out_len, busy} !== {1'b1, 16'h0040, 16'd1, 1'b1})
      begin failures++; $display("FAIL flush_stall got=%0b/%h/%0d busy=%0b exp=1/0040/1 busy=1", out_valid, out_base, out_len, busy); end
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({out_valid, out_base, out_len, busy} !== {1'b1, 16'h0050, 16'd1, 1'b0})
      begin failures++; $display("FAIL flush_release got=%0b/%h/%0d busy=%0b exp=1/0050/1 busy=0", out_valid, out_base, out_len, busy); end
    tick();
  endtask

  task automatic test_backpressure_reset();
    out_ready = 1'b0;
    beat(16'h0005, 1'b0);
    beat(16'h0009, 1'b0);
    in_valid = 1'b1; in_addr = 16'h000A;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      checks++; if ({out_valid, out_base, out_len} !== {1'b1, 16'h0005, 16'd1})
        begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%h/%0d exp=1/0005/1", i, out_valid, out_base, out_len); end
      tick();
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, busy} !== 2'b01) begin failures++; $display("FAIL bp_drain valid=%0b busy=%0b exp valid=0 busy=1", out_valid, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({out_valid, out_base, out_len, busy} !== 34'h0)
        begin failures++; $display("FAIL rst_mid got=%0b/%h/%0d busy=%0b exp=0/0000/0 busy=0", out_valid, out_base, out_len, busy); end
      tick();
    end
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_addr = 16'(i);
      tick();
      if (i == 3) begin
        checks++; if ({s_out_valid, s_out_base, s_out_len} !== {1'b1, 16'h0000, 2'd3})
          begin failures++; $display("FAIL sat_desc1 got=%0b/%h/%0d exp=1/0000/3", s_out_valid, s_out_base, s_out_len); end
      end else begin
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL sat_no_emit[%0d] got=%0b exp=0", i, s_out_valid); end
      end
    end
    s_in_valid = 1'b0;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    checks++; if ({s_out_valid, s_out_base, s_out_len} !== {1'b1, 16'h0003, 2'd2})
      begin failures++; $display("FAIL sat_desc2 got=%0b/%h/%0d exp=1/0003/2", s_out_valid, s_out_base, s_out_len); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_addr = '0;
    s_in_valid = 1'b0; s_in_start = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
    s_in_addr = '0;
    #1;
    test_reset();
    test_contiguous();
    test_break();
    test_forced_restart();
    test_wrap();
    test_back_to_back();
    test_flush_stall();
    test_backpressure_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_decode.md
# burst_decode

Receive-side counterpart of the sequential address generator: consumes a stream of `W`-bit addresses and recovers the (base, length) bursts that produced it. A burst is a maximal run of consecutive addresses, stepping by one modulo 2^W. It closes on a break, a forced restart, length saturation or flush. Each closed burst is emitted as one descriptor over a valid/ready output. The block sits downstream of the address path and feeds the burst checker/logger.

## Interface
- `W`, 16: address width.
- `LW`, 16: burst-length counter width; maximum length is 2^LW-1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: address beat present.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_addr` in W: address beat.
- `in_start` in 1: beat begins a new burst regardless of contiguity (generator `en` reload).
- `flush` in 1: close any open burst with no new beat.
- `out_valid` out 1: descriptor valid.
- `out_ready` in 1: downstream takes descriptor.
- `out_base` out W: first address of the burst.
- `out_len` out LW: number of beats in the burst, ≥1.
- `busy` out 1: a burst is open (`active`).

## Operation
- Internal state:
  - `active`: a run is open.
  - `cur_base` (W), `cur_next` (W), `cur_len` (LW).
  - Output register: `out_valid`, `out_base`, `out_len`.
- `slot_free` = !`out_valid` | `out_ready`.
- `in_ready` = `slot_free` & !`flush`.
- A beat is accepted when `in_valid` & `in_ready`.
- Accepted beat, `active`=0:
  - `cur_base` = `in_addr`, `cur_len` = 1, `cur_next` = `in_addr`+1 mod 2^W, `active` = 1.
  - No emit.
- Accepted beat, `active`=1, "continue" condition: !`in_start` & `in_addr`==`cur_next` & `cur_len` != 2^LW-1.
  - `cur_len`+1, `cur_next`+1 (mod 2^W).
- Accepted beat, `active`=1, otherwise ("break"):
  - Load the output register with (`cur_base`, `cur_len`) and set `out_valid`.
  - In the same cycle, restart the run from `in_addr` as for `active`=0.
- `flush` & `active` & `slot_free`:
  - Emit (`cur_base`, `cur_len`), `active` = 0.
  - No beat is accepted this cycle.
- `flush` with `active`=0: no effect.
- `flush` with `slot_free`=0: stalls until the slot frees; `flush` must be held by the source until then.
- `out_valid` clears when `out_ready` is high and no new emit occurs in the same cycle.
- Wrap-around: after 2^W-1, the next contiguous address is 0, and the run continues.
- Length saturation: a run at 2^LW-1 beats breaks on the next beat, even if contiguous.
- `in_start` on the first beat after idle has no extra effect.
- Arithmetic: all address/length math is unsigned and truncated to its width; no other overflow exists.

## Timing
- Reset: `active`=0, `out_valid`=0, `out_base`=0, `out_len`=0, `cur_*`=0.
  - `in_ready` follows combinationally: 1 unless `flush`.
  - `rst` overrides all other inputs in the same edge.
  - An open or pending burst is discarded, never emitted.
- Latency:
  - A descriptor becomes valid on the edge that accepts the breaking beat; it is visible the next cycle.
  - On flush, it is valid on the edge after `flush` is sampled with `slot_free`.
- Throughput: one beat per cycle while `out_ready`=1, including back-to-back breaks (every beat non-contiguous → one descriptor per cycle, each len 1).
- Descriptor fields are stable while `out_valid` & !`out_ready`.
  - `in_ready` is low in that condition even for contiguous beats (conservative, registered-friendly).
- Emit and drain in the same cycle (`out_valid`, `out_ready`, break): the new descriptor replaces the old; `out_valid` stays 1.
- Invariant for formal: `out_valid` → `out_len` ≥ 1; `active` → `cur_next` == `cur_base` + `cur_len` mod 2^W.

## Test plan
- Contiguous run, then flush.
  - Stimulus: beats 0x0100..0x0103 with `out_ready`=1, then `flush`.
  - Required: one descriptor (0x0100, 4), `busy` 0 afterwards.
- Break and restart.
  - Stimulus: beats 0x10, 0x11, 0x20, 0x21, flush.
  - Required: descriptors (0x10, 2) then (0x20, 2); the first appears the cycle after 0x20 is accepted.
- Forced restart.
  - Stimulus: 0x8000, then 0x8001 with `in_start`=1, then flush.
  - Required: descriptors (0x8000, 1) and (0x8001, 1).
- Wrap-around.
  - Stimulus: 0xFFFE, 0xFFFF, 0x0000, 0x0001, flush.
  - Required: a single descriptor (0xFFFE, 4).
- Backpressure, then reset mid-burst.
  - Stimulus: `out_ready`=0; beats 0x5, 0x9, 0xA.
  - Required: (0x5, 1) is held stable; `in_ready` is 0 from the cycle after 0x9 is accepted.
  - Stimulus: raise `out_ready`.
  - Required: the held descriptor drains; 0xA is accepted next.
  - Stimulus: assert `rst` with the run open.
  - Required: no further descriptor; all outputs 0.
- Saturation, LW=2.
  - Stimulus: beats 0..4 contiguous, flush.
  - Required: descriptors (0, 3) and (3, 2).
